bus_arbiter: RTL

Shares the core's single system-bus port between the instruction cache and the data cache. Each requester issues one 64-byte line transaction at a time. The arbiter picks a winner, drives the bus address/tag beat, streams write data, and routes read-response beats back to the owning requester. One bus transaction is outstanding at a time; the block sits between the caches and the bus pins of `Core`.

---
 rtl/bus_arb_pkg.sv | 22 ++
 rtl/bus_rr_pick.sv | 34 +++
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and tag constants for the I-cache/D-cache system-bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WDATA,
        RESP
    } arb_state_e;

    localparam logic       TAG_READ     = 1'b1;
    localparam logic       TAG_WRITE    = 1'b0;
    localparam logic [3:0] TAG_TYPE_MEM = 4'b0001;

    localparam logic [7:0] ID_IC = 8'h01;
    localparam logic [7:0] ID_DC = 8'h02;

    function automatic logic [12:0] make_tag(input logic rd, input logic [7:0] id);
        return {rd, TAG_TYPE_MEM, id};
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Two-way winner select; bit 0 = I-cache, bit 1 = D-cache.
// BUS_ARB_DCACHE_PRIO_EN turns it into fixed D-cache priority.
module bus_rr_pick (
    input  logic       ic_valid_i,
    input  logic       dc_valid_i,
    input  logic       last_dc_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = '0;
`ifdef BUS_ARB_DCACHE_PRIO_EN
        if (dc_valid_i) begin
            grant_o = 2'b10;
        end else if (ic_valid_i) begin
            grant_o = 2'b01;
        end
`else
        if (ic_valid_i && dc_valid_i) begin
            grant_o = last_dc_i ? 2'b01 : 2'b10;
        end else if (ic_valid_i) begin
            grant_o = 2'b01;
        end else if (dc_valid_i) begin
            grant_o = 2'b10;
        end
`endif
    end

`ifdef BUS_ARB_DCACHE_PRIO_EN
    logic unused_last;
    assign unused_last = last_dc_i;
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Shares the single system-bus port between I-cache and D-cache, one line transaction at a time.
// Define BUS_ARB_DCACHE_PRIO_EN for fixed D-cache priority instead of round-robin.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 ic_req_valid,
    input  logic [63:0]                          ic_req_addr,
    output logic                                 ic_req_ready,
    output logic                                 ic_rsp_valid,
    input  logic                                 dc_req_valid,
    input  logic                                 dc_req_write,
    input  logic [63:0]                          dc_req_addr,
    input  logic [LINE_BEATS*BUS_DATA_WIDTH-1:0] dc_req_wdata,
    output logic                                 dc_req_ready,
    output logic                                 dc_rsp_valid,
    output logic [BUS_DATA_WIDTH-1:0]            rsp_data,
    output logic                                 rsp_last,
    output logic                                 busy,
    output logic                                 bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]            bus_req,
    output logic [BUS_TAG_WIDTH-1:0]             bus_reqtag,
    output logic                                 bus_respack,
    input  logic                                 bus_reqack,
    input  logic                                 bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]            bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]             bus_resptag
);

    localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_BEATS - 1);

    arb_state_e                                  state_q, state_d;
    logic [CNT_W-1:0]                            cnt_q, cnt_d;
    logic                                        owner_dc_q;
    logic                                        write_q;
    logic [57:0]                                 addr_q;
    logic [LINE_BEATS-1:0][BUS_DATA_WIDTH-1:0]   wdata_q;

    logic [1:0] grant;
    logic       accept;
    logic       last_dc;
    logic [7:0] id_w;
    logic       tag_hit;

    bus_rr_pick u_pick (
        .ic_valid_i (ic_req_valid),
        .dc_valid_i (dc_req_valid),
        .last_dc_i  (last_dc),
        .grant_o    (grant)
    );

    // Reset is folded in so no request is acknowledged while held in reset.
    assign accept  = (state_q == IDLE) && !reset && (|grant);
    assign id_w    = owner_dc_q ? ID_DC : ID_IC;
    assign tag_hit = bus_respcyc && (bus_resptag[7:0] == id_w);
    assign busy    = (state_q != IDLE);

`ifdef BUS_ARB_DCACHE_PRIO_EN
    assign last_dc = 1'b0;
`else
    logic last_dc_q, last_dc_d;

    assign last_dc   = last_dc_q;
    assign last_dc_d = accept ? grant[1] : last_dc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_dc_q <= 1'b1;
        end else begin
            last_dc_q <= last_dc_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ic_req_ready = 1'b0;
        dc_req_ready = 1'b0;
        ic_rsp_valid = 1'b0;
        dc_rsp_valid = 1'b0;
        rsp_data     = '0;
        rsp_last     = 1'b0;
        bus_reqcyc   = 1'b0;
        bus_req      = '0;
        bus_reqtag   = '0;
        bus_respack  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ic_req_ready = grant[0];
                    dc_req_ready = grant[1];
                    cnt_d        = '0;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = BUS_DATA_WIDTH'({addr_q, 6'b0});
                bus_reqtag = BUS_TAG_WIDTH'(make_tag(write_q ? TAG_WRITE : TAG_READ, id_w));
                if (bus_reqack) begin
                    state_d = write_q ? WDATA : RESP;
                end
            end
            WDATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = wdata_q[cnt_q];
                bus_reqtag = BUS_TAG_WIDTH'(make_tag(TAG_WRITE, id_w));
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                bus_respack = bus_respcyc;
                // Beats tagged for another requester are acked and dropped.
                if (tag_hit) begin
                    rsp_data     = bus_resp;
                    ic_rsp_valid = !owner_dc_q;
                    dc_rsp_valid = owner_dc_q;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        rsp_last = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_dc_q <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                owner_dc_q <= grant[1];
                write_q    <= grant[1] & dc_req_write;
                addr_q     <= grant[1] ? dc_req_addr[63:6] : ic_req_addr[63:6];
                wdata_q    <= dc_req_wdata;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ic_req_addr[5:0], dc_req_addr[5:0], bus_resptag[BUS_TAG_WIDTH-1:8]};

endmodule
